// File: rtl/mux_capture_pkg.sv
// mux_capture_pkg: shared default sizes and the stored entry layout for the mux capture FIFO
package mux_capture_pkg;
    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 4;
    typedef struct packed {
        logic                     sel;
        logic [DEFAULT_WIDTH-1:0] data;
    } entry_t;
endpackage

// File: rtl/mux_capture_ram.sv
// mux_capture_ram: DEPTH x W storage with one synchronous write port and one asynchronous read port
// Ports: clk; we/waddr/wdata write on the rising edge; raddr/rdata read combinationally
module mux_capture_ram #(
    parameter int W = 3,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/mux_capture_fifo.sv
// mux_capture_fifo: captures {in_sel, in_d} words from an upstream mux into a DEPTH-entry FIFO
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_sel/in_d push side;
//        out_valid/out_ready/out_sel/out_d pop side; count occupancy; overflow sticky push-while-full.
// Optional: define MUX_CAPTURE_DROP_CNT_EN to add drop_cnt[7:0], a saturating count of dropped pushes.
module mux_capture_fifo
    import mux_capture_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_d,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [WIDTH-1:0] out_d,
    output logic [AW:0]      count,
    output logic             overflow
`ifdef MUX_CAPTURE_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [WIDTH:0] rd_entry;
    logic full, push, pop;

    assign full      = count == (AW+1)'(DEPTH);
    assign in_ready  = !full;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_sel   = rd_entry[WIDTH];
    assign out_d     = rd_entry[WIDTH-1:0];

    // A push during rst lands in storage but is discarded because the pointers reset.
    mux_capture_ram #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_sel, in_d}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Power-of-two DEPTH lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            overflow <= overflow | (in_valid & full);
        end
    end

`ifdef MUX_CAPTURE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else if (in_valid && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/mux_capture_fifo.md
MUX_CAPTURE_FIFO -- requirements
Module: mux_capture_fifo

Interface
- REQ-001: Parameter WIDTH, default 2: bit width of each captured mux data word.
- REQ-002: Parameter DEPTH, default 4: FIFO entries, power of two, >= 2.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: in_valid  input  1  upstream mux output (in_sel, in_d) is valid this cycle.
- REQ-006: in_sel  input  1  select value that produced in_d.
- REQ-007: in_d  input  WIDTH  mux output word Q.
- REQ-008: in_ready  output  1  FIFO can accept an entry.
- REQ-009: out_valid  output  1  head entry is available.
- REQ-010: out_ready  input  1  downstream accepts the head entry.
- REQ-011: out_sel  output  1  select value of the head entry.
- REQ-012: out_d  output  WIDTH  data word of the head entry.
- REQ-013: count  output  clog2(DEPTH)+1  current occupancy.
- REQ-014: overflow  output  1  sticky flag: a push was attempted while the FIFO was full.

Function
- REQ-015: Push occurs when in_valid && in_ready; the entry {in_sel, in_d} is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- REQ-016: Pop occurs when out_valid && out_ready; rd_ptr advances modulo DEPTH.
- REQ-017: in_ready SHALL be !full (count == DEPTH); it is combinational from state only and never from out_ready.
- REQ-018: out_valid SHALL be (count != 0); out_sel and out_d SHALL show the entry at rd_ptr whenever out_valid is 1.
- REQ-019: Latency: an entry pushed at edge N SHALL be visible on out_* after edge N (one-cycle latency).
- REQ-020: A simultaneous push and pop (not full, not empty) SHALL leave count unchanged and preserve order.
- REQ-021: When full, in_valid is dropped, no state other than overflow changes, and overflow SHALL be set to 1.
- REQ-022: When empty, out_ready is ignored and count SHALL NOT underflow.
- REQ-023: Pointers SHALL wrap from DEPTH-1 to 0 without loss; order SHALL be strictly FIFO.
- REQ-024: out_d and out_sel values while out_valid=0 are don't-care for checking.

Reset
- REQ-025: With rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, and any drop counter =0.
- REQ-026: Outputs after reset: in_ready=1, out_valid=0.
- REQ-027: Reset mid-operation SHALL discard all stored entries; a push in the same cycle as rst SHALL be ignored.
- REQ-028: Storage array contents need no reset.

Configuration
- REQ-029: Macro MUX_CAPTURE_DROP_CNT_EN: when defined, adds output drop_cnt [7:0], which increments on each cycle where in_valid=1 and the FIFO is full, and saturates at 255.
- REQ-030: When MUX_CAPTURE_DROP_CNT_EN is not defined, drop_cnt SHALL NOT exist, and all other behaviour is identical.

Structure
- REQ-031: Package mux_capture_pkg SHALL hold the DEFAULT_WIDTH and DEFAULT_DEPTH constants and the entry typedef {sel, data}.
- REQ-032: Storage SHALL be a sub-module mux_capture_ram (1 write port, 1 asynchronous read port, DEPTH x (WIDTH+1)).
- REQ-033: Pointer, count and flag logic reside in mux_capture_fifo.

Verification
- REQ-034: Push (sel=0, d=01), then (sel=1, d=10) with out_ready=0 -> count=2; out_sel=0 and out_d=01 on the cycle after the first push.
- REQ-035: Push 4 entries, then a 5th with in_valid=1 -> in_ready=0, count=4, overflow=1; drop_cnt=1 if the macro is defined.
- REQ-036: Fill, drain, and refill 6 entries (d=00,01,10,11,00,01) -> output order matches input order across pointer wrap.
- REQ-037: With count=2, push and pop in the same cycle -> count stays 2, and the popped entry is the oldest.
- REQ-038: With count=3 and overflow=1, assert rst for 1 cycle -> count=0, out_valid=0, in_ready=1, overflow=0.
- REQ-039: With the FIFO empty, hold out_ready=1 for 3 cycles -> count stays 0 with no spurious out_valid; bench prints PASSED.
